// File: rtl/serial_adder_pkg.sv
// Shared FSM encoding and the half-adder primitive used by the serial add path.
package serial_adder_pkg;

   typedef logic [1:0] state_t;

   localparam state_t S_IDLE = 2'd0;
   localparam state_t S_RUN  = 2'd1;
   localparam state_t S_DONE = 2'd2;

   // Returns {carry, sum} of a single half adder.
   function automatic logic [1:0] half_add(input logic a, input logic b);
      return {a & b, a ^ b};
   endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder cell: two half adders with the carries ORed, same shape
// as the subtractor cell it sits beside.
module serial_adder_full_adder
   import serial_adder_pkg::*;
(
   input  logic in_a,
   input  logic in_b,
   input  logic carry_in,
   output logic sum,
   output logic carry_out
);

   logic [1:0] ha0_s;
   logic [1:0] ha1_s;

   assign ha0_s     = half_add(in_a, in_b);
   assign ha1_s     = half_add(ha0_s[0], carry_in);
   assign sum       = ha1_s[0];
   assign carry_out = ha0_s[1] | ha1_s[1];

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands latched on start, one bit per cycle LSB
// first through a single full-adder cell, result presented with a done pulse.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state_r;
   state_t           state_next_s;
   logic             busy_next_s;
   logic             done_next_s;
   logic             busy_r;
   logic             done_r;

   logic [WIDTH-1:0] sh_a_r;
   logic [WIDTH-1:0] sh_b_r;
   logic [WIDTH-1:0] sh_r_r;
   logic             carry_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;

   logic             accept_s;
   logic             last_s;
   logic             fa_sum_s;
   logic             fa_cout_s;

   assign accept_s = (state_r == S_IDLE) && start_i;
   assign last_s   = (state_r == S_RUN) && (cnt_r == LAST_CNT);

   serial_adder_full_adder u_fa (
      .in_a      (sh_a_r[0]),
      .in_b      (sh_b_r[0]),
      .carry_in  (carry_r),
      .sum       (fa_sum_s),
      .carry_out (fa_cout_s)
   );

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // FSM next-state logic; the unused encoding falls back to IDLE
   always_comb begin
      state_next_s = S_IDLE;
      case (state_r)
         S_IDLE: begin
            if (start_i) begin
               state_next_s = S_RUN;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_RUN: begin
            if (cnt_r == LAST_CNT) begin
               state_next_s = S_DONE;
            end else begin
               state_next_s = S_RUN;
            end
         end
         S_DONE:  state_next_s = S_IDLE;
         default: state_next_s = S_IDLE;
      endcase
   end

   // FSM output decode from the upcoming state so the flags can be registered
   always_comb begin
      busy_next_s = 1'b0;
      done_next_s = 1'b0;
      case (state_next_s)
         S_RUN: begin
            busy_next_s = 1'b1;
            done_next_s = 1'b0;
         end
         S_DONE: begin
            busy_next_s = 1'b1;
            done_next_s = 1'b1;
         end
         default: begin
            busy_next_s = 1'b0;
            done_next_s = 1'b0;
         end
      endcase
   end

   // Registered status flags
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= busy_next_s;
         done_r <= done_next_s;
      end
   end

   // Operand/result shift registers, carry flip-flop and bit counter
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sh_a_r  <= {WIDTH{1'b0}};
         sh_b_r  <= {WIDTH{1'b0}};
         sh_r_r  <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
      end else if (accept_s) begin
         sh_a_r  <= a_i;
         sh_b_r  <= b_i;
         sh_r_r  <= {WIDTH{1'b0}};
         carry_r <= cin_i;
         cnt_r   <= {CNT_W{1'b0}};
      end else if (state_r == S_RUN) begin
         sh_a_r  <= {1'b0, sh_a_r[WIDTH-1:1]};
         sh_b_r  <= {1'b0, sh_b_r[WIDTH-1:1]};
         sh_r_r  <= {fa_sum_s, sh_r_r[WIDTH-1:1]};
         carry_r <= fa_cout_s;
         // Hold at the last index instead of wrapping when WIDTH is a power of two
         if (last_s) begin
            cnt_r <= cnt_r;
         end else begin
            cnt_r <= cnt_r + CNT_W'(1);
         end
      end
   end

   // Result registers: updated only on the final bit, held otherwise
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         sum_r  <= {WIDTH{1'b0}};
         cout_r <= 1'b0;
      end else if (last_s) begin
         sum_r  <= {fa_sum_s, sh_r_r[WIDTH-1:1]};
         cout_r <= fa_cout_s;
      end
   end

   assign busy_o = busy_r;
   assign done_o = done_r;
   assign sum_o  = sum_r;
   assign cout_o = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of the bit-serial adder at WIDTH=8.
module tb_serial_adder;

   localparam int WIDTH = 8;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             start_i;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             cin_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] sum_o;
   logic             cout_o;

   int vectors = 0;
   int errors  = 0;

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (start_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .cin_i   (cin_i),
      .busy_o  (busy_o),
      .done_o  (done_o),
      .sum_o   (sum_o),
      .cout_o  (cout_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   // Waits for idle, issues one start, returns edges from accept to done (30 = timeout)
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                         output int lat);
      int guard = 0;
      while (busy_o === 1'b1 && guard < 20) begin
         tick();
         guard++;
      end
      a_i = a; b_i = b; cin_i = c; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      lat = 0;
      while (done_o !== 1'b1 && lat < 30) begin
         tick();
         lat++;
      end
   endtask

   task automatic test_reset;
      rst_i = 1'b0; start_i = 1'b0; a_i = 8'h00; b_i = 8'h00; cin_i = 1'b0;
      repeat (2) tick();
      vectors++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
      vectors++;
      if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done_o); end
      vectors++;
      if ({cout_o, sum_o} !== 9'h000) begin
         errors++; $display("FAIL reset_result got %h want 000", {cout_o, sum_o});
      end
      @(posedge clk_i); #3;
      rst_i = 1'b1;
      tick();
   endtask

   task automatic test_basic;
      int lat;
      a_i = 8'h0F; b_i = 8'h01; cin_i = 1'b0; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      vectors++;
      if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", busy_o); end
      lat = 0;
      while (done_o !== 1'b1 && lat < 30) begin
         tick();
         lat++;
      end
      vectors++;
      if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
      vectors++;
      if ({cout_o, sum_o} !== 9'h010) begin
         errors++; $display("FAIL basic_sum got %h want 010", {cout_o, sum_o});
      end
      tick();
      vectors++;
      if ({busy_o, done_o} !== 2'b00) begin
         errors++; $display("FAIL basic_pulse got busy,done=%b want 00", {busy_o, done_o});
      end
   endtask

   task automatic test_carry;
      int lat;
      run_op(8'hFF, 8'h01, 1'b0, lat);
      vectors++;
      if (lat !== 8 || {cout_o, sum_o} !== 9'h100) begin
         errors++; $display("FAIL carry_wrap got lat=%0d %h want lat=8 100", lat, {cout_o, sum_o});
      end
      run_op(8'h00, 8'h00, 1'b1, lat);
      vectors++;
      if (lat !== 8 || {cout_o, sum_o} !== 9'h001) begin
         errors++; $display("FAIL carry_cin got lat=%0d %h want lat=8 001", lat, {cout_o, sum_o});
      end
   endtask

   task automatic test_start_held;
      int dones = 0;
      int first = -1;
      logic [8:0] first_res = 9'h000;
      tick();
      a_i = 8'h12; b_i = 8'h34; cin_i = 1'b0; start_i = 1'b1;
      tick();
      a_i = 8'hFF;
      for (int t = 1; t <= 17; t++) begin
         tick();
         if (t == 10) start_i = 1'b0;
         if (done_o === 1'b1) begin
            dones++;
            if (first < 0) begin
               first = t;
               first_res = {cout_o, sum_o};
            end
         end
      end
      vectors++;
      if (dones !== 1 || first !== 8) begin
         errors++; $display("FAIL held_single_done got count=%0d at=%0d want 1 at 8", dones, first);
      end
      vectors++;
      if (first_res !== 9'h046) begin
         errors++; $display("FAIL held_sum got %h want 046", first_res);
      end
      tick();
      vectors++;
      if (done_o !== 1'b1 || {cout_o, sum_o} !== 9'h133) begin
         errors++; $display("FAIL held_reaccept got done=%b %h want 1 133", done_o, {cout_o, sum_o});
      end
   endtask

   task automatic test_reset_mid_run;
      int dones = 0;
      tick();
      a_i = 8'hAA; b_i = 8'h55; cin_i = 1'b1; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      repeat (3) tick();
      rst_i = 1'b0;
      #1;
      vectors++;
      if ({busy_o, done_o, cout_o, sum_o} !== 11'h000) begin
         errors++; $display("FAIL midrun_reset got busy=%b done=%b %h want 0 0 000",
                            busy_o, done_o, {cout_o, sum_o});
      end
      @(posedge clk_i); #3;
      rst_i = 1'b1;
      for (int t = 0; t < 12; t++) begin
         tick();
         if (done_o !== 1'b0 || busy_o !== 1'b0) dones++;
      end
      vectors++;
      if (dones !== 0) begin
         errors++; $display("FAIL midrun_quiet got %0d active cycles want 0", dones);
      end
   endtask

   task automatic test_back_to_back;
      int done_at[$];
      int hold_bad = 0;
      logic [8:0] second = 9'h000;
      tick();
      a_i = 8'h3C; b_i = 8'h0F; cin_i = 1'b0; start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int t = 1; t <= 20; t++) begin
         tick();
         if (t == 9) begin
            a_i = 8'h80; b_i = 8'h90; cin_i = 1'b1; start_i = 1'b1;
         end
         if (t == 10) start_i = 1'b0;
         if (done_o === 1'b1) done_at.push_back(t);
         if (t >= 8 && t <= 17 && {cout_o, sum_o} !== 9'h04B) hold_bad++;
         if (t == 18) second = {cout_o, sum_o};
      end
      vectors++;
      if (done_at.size() !== 2) begin
         errors++; $display("FAIL b2b_count got %0d want 2", done_at.size());
      end else if (done_at[0] !== 8 || done_at[1] !== 18) begin
         errors++; $display("FAIL b2b_timing got %0d,%0d want 8,18", done_at[0], done_at[1]);
      end
      vectors++;
      if (hold_bad !== 0) begin
         errors++; $display("FAIL b2b_hold got %0d bad cycles want 0", hold_bad);
      end
      vectors++;
      if (second !== 9'h111) begin
         errors++; $display("FAIL b2b_second got %h want 111", second);
      end
   endtask

   task automatic test_random;
      int lat;
      logic [7:0] a;
      logic [7:0] b;
      logic       c;
      logic [8:0] exp;
      for (int i = 0; i < 1000; i++) begin
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         c = 1'($urandom_range(0, 1));
         exp = {1'b0, a} + {1'b0, b} + {8'h00, c};
         run_op(a, b, c, lat);
         vectors++;
         if (lat !== 8 || {cout_o, sum_o} !== exp) begin
            errors++;
            $display("FAIL random_%0d a=%h b=%h cin=%b got lat=%0d %h want lat=8 %h",
                     i, a, b, c, lat, {cout_o, sum_o}, exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_carry();
      test_start_held();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
